// File: rtl/top_if.sv
`default_nettype none
// ============================================================================
//  Module   : top_if
//  Brief    : Operand / result bundle between the ALU and its user.
//  Revision : 1.0
// ============================================================================
interface top_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [3:0]       op_code;
  logic             cin;
  logic             bin;
  logic [WIDTH-1:0] rslt;
  logic             cout;
  logic             zero;

  modport master (
    output input1, input2, op_code, cin, bin,
    input  rslt, cout, zero
  );

  modport slave (
    input  input1, input2, op_code, cin, bin,
    output rslt, cout, zero
  );
endinterface
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
//  Module   : top
//  Brief    : Single-cycle-latency 16-function ALU with registered result/flag.
//  Revision : 1.0
// ============================================================================
module top #(
  parameter int WIDTH = 16
) (
  input  wire   clk,
  input  wire   rst,
  top_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] c_ADD  = 4'd0;
  localparam logic [3:0] c_SUB  = 4'd1;
  localparam logic [3:0] c_AND  = 4'd2;
  localparam logic [3:0] c_OR   = 4'd3;
  localparam logic [3:0] c_XOR  = 4'd4;
  localparam logic [3:0] c_NOT  = 4'd5;
  localparam logic [3:0] c_NAND = 4'd6;
  localparam logic [3:0] c_NOR  = 4'd7;
  localparam logic [3:0] c_XNOR = 4'd8;
  localparam logic [3:0] c_SHL  = 4'd9;
  localparam logic [3:0] c_SHR  = 4'd10;
  localparam logic [3:0] c_SRA  = 4'd11;
  localparam logic [3:0] c_ROL  = 4'd12;
  localparam logic [3:0] c_ROR  = 4'd13;
  localparam logic [3:0] c_INC  = 4'd14;
  localparam logic [3:0] c_SLT  = 4'd15;

  logic [WIDTH-1:0]   r_rslt;
  logic               r_cout;
  logic [WIDTH-1:0]   w_rslt;
  logic               w_cout;
  logic [SHW-1:0]     w_n;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_inc;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sra;
  logic [2*WIDTH-1:0] w_rol;
  logic [2*WIDTH-1:0] w_ror;

  assign w_n = bus.input2[SHW-1:0];

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra position; an amount of zero then naturally yields a zero flag.
  assign w_sum  = {1'b0, bus.input1} + {1'b0, bus.input2} + {{WIDTH{1'b0}}, bus.cin};
  assign w_diff = {1'b0, bus.input1} - {1'b0, bus.input2} - {{WIDTH{1'b0}}, bus.bin};
  assign w_inc  = {1'b0, bus.input1} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shl  = {1'b0, bus.input1} << w_n;
  assign w_shr  = {bus.input1, 1'b0} >> w_n;
  assign w_sra  = $signed({bus.input1, 1'b0}) >>> w_n;
  assign w_rol  = {bus.input1, bus.input1} << w_n;
  assign w_ror  = {bus.input1, bus.input1} >> w_n;

  always_comb begin
    w_rslt = '0;
    w_cout = 1'b0;
    case (bus.op_code)
      c_ADD:  {w_cout, w_rslt} = w_sum;
      c_SUB:  {w_cout, w_rslt} = w_diff;
      c_AND:  w_rslt = bus.input1 & bus.input2;
      c_OR:   w_rslt = bus.input1 | bus.input2;
      c_XOR:  w_rslt = bus.input1 ^ bus.input2;
      c_NOT:  w_rslt = ~bus.input1;
      c_NAND: w_rslt = ~(bus.input1 & bus.input2);
      c_NOR:  w_rslt = ~(bus.input1 | bus.input2);
      c_XNOR: w_rslt = ~(bus.input1 ^ bus.input2);
      c_SHL:  {w_cout, w_rslt} = w_shl;
      c_SHR:  {w_rslt, w_cout} = w_shr;
      c_SRA:  {w_rslt, w_cout} = w_sra;
      c_ROL:  w_rslt = w_rol[2*WIDTH-1:WIDTH];
      c_ROR:  w_rslt = w_ror[WIDTH-1:0];
      c_INC:  {w_cout, w_rslt} = w_inc;
      c_SLT:  w_rslt = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rslt <= '0;
      r_cout <= 1'b0;
    end else begin
      r_rslt <= w_rslt;
      r_cout <= w_cout;
    end
  end

  assign bus.rslt = r_rslt;
  assign bus.cout = r_cout;
  assign bus.zero = (r_rslt == '0);
endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_top
//  Brief    : Directed and randomised self-checking bench for the ALU top.
//  Revision : 1.0
// ============================================================================
module tb_top;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  top_if #(.WIDTH(16)) bus ();

  top #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: {cout, rslt} for one operation.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input logic ci,
                                        input logic bi);
    logic [15:0] r;
    logic        c;
    int          n;
    int          s;
    n = int'(b[3:0]);
    r = 16'h0;
    c = 1'b0;
    case (op)
      4'd0: begin s = int'(a) + int'(b) + int'(ci); r = s[15:0]; c = s[16]; end
      4'd1: begin r = a - b - 16'(bi); c = (int'(a) < int'(b) + int'(bi)); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = ~(a & b);
      4'd7: r = ~(a | b);
      4'd8: r = ~(a ^ b);
      4'd9: begin r = a << n; c = (n > 0) ? a[16-n] : 1'b0; end
      4'd10: begin r = a >> n; c = (n > 0) ? a[n-1] : 1'b0; end
      4'd11: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[15], r[15:1]};
        c = (n > 0) ? a[n-1] : 1'b0;
      end
      4'd12: r = (n > 0) ? ((a << n) | (a >> (16 - n))) : a;
      4'd13: r = (n > 0) ? ((a >> n) | (a << (16 - n))) : a;
      4'd14: begin s = int'(a) + 1; r = s[15:0]; c = s[16]; end
      default: r = (a < b) ? 16'd1 : 16'd0;
    endcase
    return {c, r};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one operation, clock it in, then compare cout/rslt and zero.
  task automatic step(input string tag, input logic r, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] op, input logic ci,
                      input logic bi, input logic [15:0] er, input logic ec);
    rst = r;
    bus.input1 = a;
    bus.input2 = b;
    bus.op_code = op;
    bus.cin = ci;
    bus.bin = bi;
    @(posedge clk);
    #1;
    check({tag, ".rslt"}, {1'b0, bus.rslt}, {1'b0, er});
    check({tag, ".cout"}, {16'h0, bus.cout}, {16'h0, ec});
    check({tag, ".zero"}, {16'h0, bus.zero}, {16'h0, (er == 16'h0)});
  endtask

  initial begin
    logic [15:0] a, b;
    logic [3:0]  op;
    logic        ci, bi, rs;
    logic [16:0] exp;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.input1 = '0;
    bus.input2 = '0;
    bus.op_code = '0;
    bus.cin = 1'b0;
    bus.bin = 1'b0;
    #2;

    step("reset",     1'b1, 16'hFFFF, 16'h0001, 4'd0,  1'b1, 1'b0, 16'h0000, 1'b0);
    step("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 4'd0,  1'b1, 1'b0, 16'h0001, 1'b1);
    step("add_zero",  1'b0, 16'hFFFF, 16'h0001, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1);
    step("sub_brw",   1'b0, 16'd5,    16'd7,    4'd1,  1'b0, 1'b1, 16'hFFFD, 1'b1);
    step("sub_ok",    1'b0, 16'd7,    16'd5,    4'd1,  1'b1, 1'b0, 16'd2,    1'b0);
    step("sub_eq_bin",1'b0, 16'd5,    16'd5,    4'd1,  1'b0, 1'b1, 16'hFFFF, 1'b1);
    step("and",       1'b0, 16'hF0F0, 16'hFF00, 4'd2,  1'b1, 1'b1, 16'hF000, 1'b0);
    step("or",        1'b0, 16'hF0F0, 16'hFF00, 4'd3,  1'b0, 1'b0, 16'hFFF0, 1'b0);
    step("xor",       1'b0, 16'hF0F0, 16'hFF00, 4'd4,  1'b0, 1'b0, 16'h0FF0, 1'b0);
    step("not",       1'b0, 16'hF0F0, 16'hFF00, 4'd5,  1'b0, 1'b0, 16'h0F0F, 1'b0);
    step("nand",      1'b0, 16'hF0F0, 16'hFF00, 4'd6,  1'b0, 1'b0, 16'h0FFF, 1'b0);
    step("nor",       1'b0, 16'hF0F0, 16'hFF00, 4'd7,  1'b0, 1'b0, 16'h000F, 1'b0);
    step("xnor",      1'b0, 16'hF0F0, 16'hFF00, 4'd8,  1'b0, 1'b0, 16'hF00F, 1'b0);
    step("shl",       1'b0, 16'h8001, 16'h0001, 4'd9,  1'b0, 1'b0, 16'h0002, 1'b1);
    step("shr",       1'b0, 16'h8001, 16'h0001, 4'd10, 1'b0, 1'b0, 16'h4000, 1'b1);
    step("sra",       1'b0, 16'h8001, 16'h0001, 4'd11, 1'b0, 1'b0, 16'hC000, 1'b1);
    step("rol",       1'b0, 16'h8001, 16'h0001, 4'd12, 1'b0, 1'b0, 16'h0003, 1'b0);
    step("ror",       1'b0, 16'h8001, 16'h0001, 4'd13, 1'b0, 1'b0, 16'hC000, 1'b0);
    step("shl_hi_b",  1'b0, 16'h8001, 16'hFFF1, 4'd9,  1'b1, 1'b0, 16'h0002, 1'b1);
    step("shl_n0",    1'b0, 16'h8001, 16'h0010, 4'd9,  1'b0, 1'b0, 16'h8001, 1'b0);
    step("shl_n15",   1'b0, 16'h0003, 16'h000F, 4'd9,  1'b0, 1'b0, 16'h8000, 1'b1);
    step("sra_n4",    1'b0, 16'h8F00, 16'h0004, 4'd11, 1'b0, 1'b0, 16'hF8F0, 1'b0);
    step("ror_n0",    1'b0, 16'h1234, 16'h0000, 4'd13, 1'b0, 1'b0, 16'h1234, 1'b0);
    step("inc_wrap",  1'b0, 16'hFFFF, 16'h1234, 4'd14, 1'b1, 1'b0, 16'h0000, 1'b1);
    step("slt_true",  1'b0, 16'h0001, 16'h8000, 4'd15, 1'b0, 1'b0, 16'h0001, 1'b0);
    step("slt_eq",    1'b0, 16'h8000, 16'h8000, 4'd15, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Randomised stream with a reset pulse in the middle.
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 4'($urandom_range(0, 15));
      ci = 1'($urandom);
      bi = 1'($urandom);
      rs = (i == 500);
      exp = rs ? 17'h0 : model(a, b, op, ci, bi);
      step(rs ? "rand_rst" : "rand", rs, a, b, op, ci, bi, exp[15:0], exp[16]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter WIDTH, default 16, is the data width of input1, input2 and rslt; all requirements below assume WIDTH=16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 input1  input  16  operand A, unsigned.
REQ-005 input2  input  16  operand B, unsigned.
REQ-006 op_code  input  4  operation select.
REQ-007 cin  input  1  carry-in, used by ADD only.
REQ-008 bin  input  1  borrow-in, used by SUB only.
REQ-009 rslt  output  16  registered operation result.
REQ-010 cout  output  1  registered carry/borrow/shift-out flag.
REQ-011 zero  output  1  combinational, 1 when rslt == 0.

Function
REQ-012 Inputs are sampled on each rising clk edge; rslt and cout update on that edge (one-cycle latency, no handshake, a new operation every cycle).
REQ-013 op 0 ADD: {cout,rslt} = input1 + input2 + cin (17-bit sum).
REQ-014 op 1 SUB: rslt = (input1 - input2 - bin) mod 2^16; cout = 1 when input1 < input2 + bin (borrow out).
REQ-015 op 2 AND: rslt = input1 & input2; cout = 0.
REQ-016 op 3 OR: rslt = input1 | input2; cout = 0.
REQ-017 op 4 XOR: rslt = input1 ^ input2; cout = 0.
REQ-018 op 5 NOT: rslt = ~input1; input2 ignored; cout = 0.
REQ-019 op 6 NAND, op 7 NOR, op 8 XNOR: bitwise on input1, input2; cout = 0.
REQ-020 op 9 SHL: rslt = input1 << input2[3:0]; cout = last bit shifted out (input1[16-n] for n>0), 0 when n = 0.
REQ-021 op 10 SHR (logical): rslt = input1 >> input2[3:0]; cout = input1[n-1] for n>0, 0 when n = 0.
REQ-022 op 11 SRA: arithmetic right shift of input1 by input2[3:0], sign bit replicated; cout as SHR.
REQ-023 op 12 ROL / op 13 ROR: rotate input1 by input2[3:0]; cout = 0; amount 0 passes input1 unchanged.
REQ-024 op 14 INC: {cout,rslt} = input1 + 1; input2, cin ignored.
REQ-025 op 15 SLT: rslt = 16'd1 if input1 < input2 (unsigned) else 16'd0; cout = 0.
REQ-026 Upper bits input2[15:4] are ignored for ops 9-13.
REQ-027 cin affects only op 0 and bin affects only op 1; both ignored otherwise.
REQ-028 Overflow wraps modulo 2^16; no saturation.
REQ-029 X/unknown-free: every op_code value (0-15) is defined; there is no default/illegal state.

Reset
REQ-030 While rst = 1 at a rising edge, rslt <= 0 and cout <= 0, regardless of other inputs; zero therefore reads 1.
REQ-031 rst takes priority over any operation in the same cycle; the first edge with rst = 0 loads the computed result of the inputs present at that edge.
REQ-032 Before the first reset, output values are unspecified.

Verification
REQ-033 Reset: rst=1, input1=0xFFFF, input2=1, op=0, one edge -> rslt=0, cout=0, zero=1.
REQ-034 ADD wrap: input1=0xFFFF, input2=0x0001, cin=1, op=0 -> next edge rslt=0x0001, cout=1, zero=0.
REQ-035 SUB borrow: input1=5, input2=7, bin=1, op=1 -> rslt=0xFFFD, cout=1; input1=7, input2=5, bin=0 -> rslt=2, cout=0.
REQ-036 Logic: input1=0xF0F0, input2=0xFF00: op2 -> 0xF000, op3 -> 0xFFF0, op4 -> 0x0FF0, op5 -> 0x0F0F, each one cycle after apply.
REQ-037 Shifts: input1=0x8001, input2=1: op9 -> 0x0002 cout=1; op10 -> 0x4000 cout=1; op11 -> 0xC000 cout=1; op12 -> 0x0003; op13 -> 0xC000.
REQ-038 Random: 1000 cycles of random input1/input2/op_code/cin/bin compared against a reference model with one-cycle delay, including a rst pulse mid-stream -> rslt=0 on the reset edge, correct results resume the following edge.
